cvxif_result_tracker: RTL and testbench
=======================================

Name: cvxif_result_tracker

Overview:
- Sits directly downstream of the issue stage's CV-X-IF issue/commit interface. It consumes offload handshakes and coprocessor results, and produces scoreboard writebacks on one execute write-back port.
- Tracks outstanding offloaded transaction IDs and matches returning results to them.
- Synthesises illegal-instruction exceptions for offloads the coprocessor rejects.
- Buffers writebacks so that a result and a rejection in the same cycle both retire.

Parameters:
- XLEN, 64, data width of results and exception tval.
- ID_BITS, 3, transaction ID width; must equal the scoreboard trans_id width.
- MAX_OUTSTANDING, 4, maximum number of accepted offloads awaiting a result (1..2**ID_BITS).
- FIFO_DEPTH, 4, writeback buffer depth (>=2, power of two).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  pipeline flush; drops all tracked state
- issue_valid_i  in  1  offload presented (x_issue_valid from issue stage)
- issue_ready_o  out  1  tracker can accept a new offload
- issue_id_i  in  ID_BITS  transaction ID of the offload
- issue_instr_i  in  32  offloaded instruction word (used as tval on reject)
- issue_accept_i  in  1  coprocessor accepted the offload (x_issue_resp.accept)
- issue_writeback_i  in  1  coprocessor will write rd (x_issue_resp.writeback)
- result_valid_i  in  1  coprocessor result valid
- result_ready_o  out  1  tracker can take a result
- result_id_i  in  ID_BITS  result transaction ID
- result_data_i  in  XLEN  result data
- result_exc_i  in  1  coprocessor signals an exception
- result_exccode_i  in  6  exception code
- wb_valid_o  out  1  writeback to scoreboard (one-cycle pulse per entry)
- wb_trans_id_o  out  ID_BITS  writeback transaction ID
- wb_data_o  out  XLEN  writeback data
- wb_we_o  out  1  rd write enable (cvxif_rd)
- wb_ex_valid_o  out  1  writeback carries an exception
- wb_ex_cause_o  out  XLEN  exception cause, zero-extended
- wb_ex_tval_o  out  XLEN  exception tval, zero-extended instruction word
- spurious_o  out  1  one-cycle pulse: a result ID was not outstanding
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  number of tracked offloads

Behaviour:

Reset and flush:
- Reset (rst_i high at a clock edge) clears the table, FIFO and counters.
- After reset all outputs are 0, except result_ready_o=1 and issue_ready_o=1.
- flush_i has priority over every same-cycle event: no push, no table update, and the FIFO is emptied.
- wb_valid_o=0 in the cycle after a flush.

Offload handshake (issue_fire = issue_valid_i & issue_ready_o):
- issue_ready_o = (outstanding < MAX_OUTSTANDING) & ~tracked[issue_id_i] & (FIFO free >= 2).
- On issue_fire with issue_accept_i=1: set tracked[id] and store the writeback flag; outstanding +1 visible next cycle.
- On issue_fire with issue_accept_i=0: push a reject writeback (ex_valid=1, cause=2, tval=issue_instr_i, we=0, data=0). The table is not updated.

Result handshake (result_fire = result_valid_i & result_ready_o):
- result_ready_o = FIFO free >= 2, so a same-cycle reject always has room.
- On result_fire with tracked[id]=1: push a result writeback (data, we=stored writeback flag & ~result_exc_i, ex_valid=result_exc_i, cause=exccode, tval=0). Clear tracked[id]; outstanding -1.
- On result_fire with tracked[id]=0: drop the result and pulse spurious_o in the next cycle.

FIFO and writeback output:
- Up to 2 pushes per cycle. When a result and a reject both push, the result is written first.
- The scoreboard always accepts writebacks, so the FIFO pops its head every cycle it is non-empty.
- wb_* are registered from the FIFO head. Latency is 1 cycle from fire to wb_valid_o when the FIFO is empty; otherwise strict FIFO order.
- wb_* data fields are 0 when wb_valid_o=0.

Outstanding counter and ID reuse:
- Simultaneous issue and result in the same cycle leave outstanding unchanged.
- A result for ID k and a new issue for ID k in the same cycle: issue_ready_o uses the registered tracked[k], so the issue is refused this cycle.
- The FIFO pointers wrap modulo FIFO_DEPTH. An overflow is unreachable by construction; an assertion checks it.

Test Plan:
- Accept then result: issue id=3, accept=1, writeback=1; result id=3, data=0xDEAD two cycles later -> wb_valid_o pulse 1 cycle after result_fire, trans_id=3, data=0xDEAD, we=1, ex=0; outstanding 1 then 0.
- Reject: issue id=5, accept=0, instr=0x0000_702B -> next cycle wb ex_valid=1, cause=2, tval=0x702B, we=0; outstanding stays 0.
- Collision: result id=1 and reject of id=2 in the same cycle -> wb id=1 at cycle+1, then wb id=2 at cycle+2.
- Full: 4 accepted offloads (ids 0-3) -> issue_ready_o=0 with a 5th pending; a result for id 0 -> issue_ready_o=1 the next cycle.
- Flush: 2 outstanding plus FIFO holding 1 entry, assert flush_i -> wb_valid_o=0 next cycle, outstanding=0; a later result id=0 is dropped with spurious_o=1.
- Reset mid-operation: rst_i high while FIFO is non-empty -> all outputs at reset values next cycle; no wb_valid_o pulse.

Source files
------------

// File: rtl/cvxif_result_tracker.sv
// Tracks offloaded CV-X-IF transactions and turns coprocessor results and rejects
// into scoreboard writebacks, buffered so a same-cycle result and reject both retire.
module cvxif_result_tracker #(
  parameter int XLEN            = 64,
  parameter int ID_BITS         = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic                                 issue_valid_i,
  output logic                                 issue_ready_o,
  input  logic [ID_BITS-1:0]                   issue_id_i,
  input  logic [31:0]                          issue_instr_i,
  input  logic                                 issue_accept_i,
  input  logic                                 issue_writeback_i,
  input  logic                                 result_valid_i,
  output logic                                 result_ready_o,
  input  logic [ID_BITS-1:0]                   result_id_i,
  input  logic [XLEN-1:0]                      result_data_i,
  input  logic                                 result_exc_i,
  input  logic [5:0]                           result_exccode_i,
  output logic                                 wb_valid_o,
  output logic [ID_BITS-1:0]                   wb_trans_id_o,
  output logic [XLEN-1:0]                      wb_data_o,
  output logic                                 wb_we_o,
  output logic                                 wb_ex_valid_o,
  output logic [XLEN-1:0]                      wb_ex_cause_o,
  output logic [XLEN-1:0]                      wb_ex_tval_o,
  output logic                                 spurious_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);
  localparam int NUM_IDS = 2 ** ID_BITS;
  localparam int OW      = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW     = $clog2(FIFO_DEPTH + 1);
  localparam int PW      = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [ID_BITS-1:0] id;
    logic [XLEN-1:0]    data;
    logic               we;
    logic               ex;
    logic [5:0]         cause;
    logic [31:0]        tval;
  } wb_entry_t;

  logic [NUM_IDS-1:0] tracked_q, tracked_d, wb_flag_q, wb_flag_d;
  logic [OW-1:0]      outstanding_q, outstanding_d;
  wb_entry_t          mem_q [FIFO_DEPTH];
  wb_entry_t          mem_d [FIFO_DEPTH];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [FCW-1:0]     cnt_q, cnt_d;
  wb_entry_t          wb_q, wb_d;
  logic               wb_valid_q, wb_valid_d;
  logic               spurious_q, spurious_d;

  logic               fifo_room, issue_fire, result_fire, acc_fire, res_hit, rej;
  logic [1:0]         n_push;
  wb_entry_t          res_entry, rej_entry, p0;

  // Two free slots are always reserved so a result and a reject can land together.
  assign fifo_room      = cnt_q <= FCW'(FIFO_DEPTH - 2);
  assign issue_ready_o  = (outstanding_q < OW'(MAX_OUTSTANDING)) & ~tracked_q[issue_id_i] & fifo_room;
  assign result_ready_o = fifo_room;

  assign issue_fire  = issue_valid_i & issue_ready_o;
  assign result_fire = result_valid_i & result_ready_o;
  assign acc_fire    = issue_fire & issue_accept_i;
  assign rej         = issue_fire & ~issue_accept_i;
  assign res_hit     = result_fire & tracked_q[result_id_i];
  assign n_push      = {1'b0, res_hit} + {1'b0, rej};

  always_comb begin
    res_entry       = '0;
    res_entry.id    = result_id_i;
    res_entry.data  = result_data_i;
    res_entry.we    = wb_flag_q[result_id_i] & ~result_exc_i;
    res_entry.ex    = result_exc_i;
    res_entry.cause = result_exccode_i;
    rej_entry       = '0;
    rej_entry.id    = issue_id_i;
    rej_entry.ex    = 1'b1;
    rej_entry.cause = 6'd2;
    rej_entry.tval  = issue_instr_i;
    p0              = res_hit ? res_entry : rej_entry;
  end

  always_comb begin
    tracked_d     = tracked_q;
    wb_flag_d     = wb_flag_q;
    outstanding_d = outstanding_q;
    mem_d         = mem_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    cnt_d         = cnt_q;
    wb_d          = '0;
    wb_valid_d    = 1'b0;
    spurious_d    = 1'b0;
    if (flush_i) begin
      tracked_d     = '0;
      outstanding_d = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      cnt_d         = '0;
    end else begin
      if (acc_fire) begin
        tracked_d[issue_id_i] = 1'b1;
        wb_flag_d[issue_id_i] = issue_writeback_i;
      end
      if (res_hit) tracked_d[result_id_i] = 1'b0;
      outstanding_d = outstanding_q + OW'(acc_fire) - OW'(res_hit);
      spurious_d    = result_fire & ~tracked_q[result_id_i];
      if (cnt_q != '0) begin
        wb_d       = mem_q[rd_ptr_q];
        wb_valid_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + PW'(1);
        if (n_push != 2'd0) mem_d[wr_ptr_q] = p0;
        if (n_push == 2'd2) mem_d[wr_ptr_q + PW'(1)] = rej_entry;
        wr_ptr_d = wr_ptr_q + PW'(n_push);
        cnt_d    = cnt_q - FCW'(1) + FCW'(n_push);
      end else if (n_push != 2'd0) begin
        // Empty buffer: first push bypasses straight into the output register.
        wb_d       = p0;
        wb_valid_d = 1'b1;
        if (n_push == 2'd2) begin
          mem_d[wr_ptr_q] = rej_entry;
          wr_ptr_d        = wr_ptr_q + PW'(1);
          cnt_d           = FCW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tracked_q     <= '0;
      wb_flag_q     <= '0;
      outstanding_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      wb_q          <= '0;
      wb_valid_q    <= 1'b0;
      spurious_q    <= 1'b0;
    end else begin
      tracked_q     <= tracked_d;
      wb_flag_q     <= wb_flag_d;
      outstanding_q <= outstanding_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
      wb_q          <= wb_d;
      wb_valid_q    <= wb_valid_d;
      spurious_q    <= spurious_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  logic [FCW:0] fill_total;
  assign fill_total = {1'b0, cnt_q} + (FCW + 1)'(n_push);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    fill_total <= (FCW + 1)'(FIFO_DEPTH + 1));

  assign wb_valid_o    = wb_valid_q;
  assign wb_trans_id_o = wb_q.id;
  assign wb_data_o     = wb_q.data;
  assign wb_we_o       = wb_q.we;
  assign wb_ex_valid_o = wb_q.ex;
  assign wb_ex_cause_o = XLEN'(wb_q.cause);
  assign wb_ex_tval_o  = XLEN'(wb_q.tval);
  assign spurious_o    = spurious_q;
  assign outstanding_o = outstanding_q;
endmodule

// File: tb/tb_cvxif_result_tracker.sv
// Directed bench for cvxif_result_tracker; expected values are hand-computed constants.
module tb_cvxif_result_tracker;
  logic        clk_i = 1'b0;
  logic        rst_i, flush_i;
  logic        issue_valid_i, issue_ready_o;
  logic [2:0]  issue_id_i;
  logic [31:0] issue_instr_i;
  logic        issue_accept_i, issue_writeback_i;
  logic        result_valid_i, result_ready_o;
  logic [2:0]  result_id_i;
  logic [63:0] result_data_i;
  logic        result_exc_i;
  logic [5:0]  result_exccode_i;
  logic        wb_valid_o;
  logic [2:0]  wb_trans_id_o;
  logic [63:0] wb_data_o;
  logic        wb_we_o, wb_ex_valid_o;
  logic [63:0] wb_ex_cause_o, wb_ex_tval_o;
  logic        spurious_o;
  logic [2:0]  outstanding_o;

  int n_checks = 0;
  int n_fails  = 0;

  cvxif_result_tracker dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_id_i(issue_id_i),
    .issue_instr_i(issue_instr_i), .issue_accept_i(issue_accept_i),
    .issue_writeback_i(issue_writeback_i),
    .result_valid_i(result_valid_i), .result_ready_o(result_ready_o),
    .result_id_i(result_id_i), .result_data_i(result_data_i), .result_exc_i(result_exc_i),
    .result_exccode_i(result_exccode_i),
    .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o), .wb_data_o(wb_data_o),
    .wb_we_o(wb_we_o), .wb_ex_valid_o(wb_ex_valid_o), .wb_ex_cause_o(wb_ex_cause_o),
    .wb_ex_tval_o(wb_ex_tval_o), .spurious_o(spurious_o), .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i = 0; issue_valid_i = 0; issue_id_i = 0; issue_instr_i = 0;
    issue_accept_i = 0; issue_writeback_i = 0; result_valid_i = 0; result_id_i = 0;
    result_data_i = 0; result_exc_i = 0; result_exccode_i = 0;
  endtask

  task automatic issue(input logic [2:0] id, input logic acc, input logic wbk, input logic [31:0] instr);
    issue_valid_i = 1; issue_id_i = id; issue_accept_i = acc;
    issue_writeback_i = wbk; issue_instr_i = instr;
  endtask

  task automatic result(input logic [2:0] id, input logic [63:0] data);
    result_valid_i = 1; result_id_i = id; result_data_i = data;
  endtask

  initial begin
    idle_inputs();
    rst_i = 1;
    tick(); tick();
    rst_i = 0;
    #1;
    check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("rst_issue_rdy", 64'(issue_ready_o), 64'd1);
    check("rst_result_rdy", 64'(result_ready_o), 64'd1);
    check("rst_outstanding", 64'(outstanding_o), 64'd0);
    check("rst_spurious", 64'(spurious_o), 64'd0);
    check("rst_wb_data", wb_data_o, 64'd0);

    // Accept then result two cycles later
    issue(3'd3, 1, 1, 32'h0);
    tick(); idle_inputs();
    check("acc_outstanding1", 64'(outstanding_o), 64'd1);
    check("acc_no_wb", 64'(wb_valid_o), 64'd0);
    tick();
    result(3'd3, 64'hDEAD);
    tick(); idle_inputs();
    check("res_wb_valid", 64'(wb_valid_o), 64'd1);
    check("res_wb_id", 64'(wb_trans_id_o), 64'd3);
    check("res_wb_data", wb_data_o, 64'hDEAD);
    check("res_wb_we", 64'(wb_we_o), 64'd1);
    check("res_wb_ex", 64'(wb_ex_valid_o), 64'd0);
    check("res_outstanding0", 64'(outstanding_o), 64'd0);
    tick();
    check("res_pulse_end", 64'(wb_valid_o), 64'd0);

    // Reject
    issue(3'd5, 0, 0, 32'h0000_702B);
    tick(); idle_inputs();
    check("rej_wb_valid", 64'(wb_valid_o), 64'd1);
    check("rej_wb_id", 64'(wb_trans_id_o), 64'd5);
    check("rej_ex", 64'(wb_ex_valid_o), 64'd1);
    check("rej_cause", wb_ex_cause_o, 64'd2);
    check("rej_tval", wb_ex_tval_o, 64'h702B);
    check("rej_we", 64'(wb_we_o), 64'd0);
    check("rej_data", wb_data_o, 64'd0);
    check("rej_outstanding", 64'(outstanding_o), 64'd0);

    // Collision: result id1 and reject id2 in the same cycle
    issue(3'd1, 1, 1, 32'h0);
    tick(); idle_inputs();
    tick();
    result(3'd1, 64'h11);
    issue(3'd2, 0, 0, 32'h1234);
    tick(); idle_inputs();
    check("col_first_valid", 64'(wb_valid_o), 64'd1);
    check("col_first_id", 64'(wb_trans_id_o), 64'd1);
    check("col_first_ex", 64'(wb_ex_valid_o), 64'd0);
    check("col_first_data", wb_data_o, 64'h11);
    tick();
    check("col_second_valid", 64'(wb_valid_o), 64'd1);
    check("col_second_id", 64'(wb_trans_id_o), 64'd2);
    check("col_second_ex", 64'(wb_ex_valid_o), 64'd1);
    check("col_second_tval", wb_ex_tval_o, 64'h1234);
    tick();
    check("col_drained", 64'(wb_valid_o), 64'd0);

    // Full: four accepted offloads with writeback=0
    for (int i = 0; i < 4; i++) begin
      issue(3'(i), 1, 0, 32'h0);
      tick();
    end
    idle_inputs();
    check("full_outstanding", 64'(outstanding_o), 64'd4);
    issue(3'd4, 1, 0, 32'h0);
    #1;
    check("full_issue_rdy", 64'(issue_ready_o), 64'd0);
    result(3'd0, 64'h55);
    tick();
    result_valid_i = 0;
    #1;
    check("full_freed_rdy", 64'(issue_ready_o), 64'd1);
    check("full_outstanding3", 64'(outstanding_o), 64'd3);
    check("full_wb_we0", 64'(wb_we_o), 64'd0);
    check("full_wb_id0", 64'(wb_trans_id_o), 64'd0);
    idle_inputs();

    // Same-cycle result and re-issue of the same ID: issue refused
    result(3'd3, 64'h33);
    issue(3'd3, 1, 0, 32'h0);
    #1;
    check("reuse_refused", 64'(issue_ready_o), 64'd0);
    tick(); idle_inputs();
    check("reuse_outstanding", 64'(outstanding_o), 64'd2);

    // Flush with 2 outstanding (ids 1,2) and one buffered entry
    tick();
    result(3'd1, 64'h77);
    issue(3'd6, 0, 0, 32'hABCD);
    tick(); idle_inputs();
    check("pre_flush_wb", 64'(wb_valid_o), 64'd1);
    check("pre_flush_outstanding", 64'(outstanding_o), 64'd1);
    issue(3'd5, 1, 0, 32'h0);
    tick(); idle_inputs();
    check("pre_flush_outst2", 64'(outstanding_o), 64'd2);
    check("pre_flush_buffered", 64'(wb_trans_id_o), 64'd6);
    issue(3'd4, 0, 0, 32'h99);
    result(3'd2, 64'h22);
    tick(); idle_inputs();
    // One entry (reject id4) is now buffered behind the id2 result on the output.
    flush_i = 1;
    tick(); flush_i = 0;
    check("flush_wb_valid", 64'(wb_valid_o), 64'd0);
    check("flush_outstanding", 64'(outstanding_o), 64'd0);
    tick();
    check("flush_fifo_empty", 64'(wb_valid_o), 64'd0);
    result(3'd0, 64'h1);
    tick(); idle_inputs();
    check("flush_spurious", 64'(spurious_o), 64'd1);
    check("flush_spur_no_wb", 64'(wb_valid_o), 64'd0);
    tick();
    check("spurious_pulse_end", 64'(spurious_o), 64'd0);

    // Reset mid-operation with a non-empty buffer
    issue(3'd7, 1, 1, 32'h0);
    tick();
    issue(3'd0, 1, 1, 32'h0);
    tick(); idle_inputs();
    result(3'd0, 64'h5);
    issue(3'd1, 0, 0, 32'h4242);
    tick(); idle_inputs();
    check("pre_rst_wb", 64'(wb_valid_o), 64'd1);
    rst_i = 1;
    tick(); rst_i = 0;
    #1;
    check("mid_rst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("mid_rst_outstanding", 64'(outstanding_o), 64'd0);
    check("mid_rst_tval", wb_ex_tval_o, 64'd0);
    check("mid_rst_issue_rdy", 64'(issue_ready_o), 64'd1);
    tick();
    check("mid_rst_no_pulse", 64'(wb_valid_o), 64'd0);
    check("mid_rst_id_free", 64'(outstanding_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
